// File: rtl/pipe_latch_pkg.sv
// Shared definitions for the pipeline-stage latch: state encoding and the
// bubble (empty-stage) data pattern.
package pipe_latch_pkg;

   // Upper bound on NCH*WIDTH supported by bubble_word.
   localparam int MAX_BITS = 1024;

   // Encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_t;

   // All lanes zero except lane ir_ch, which carries the low width bits of nop_ir.
   function automatic logic [MAX_BITS-1:0] bubble_word(input int nch, input int width,
                                                       input int ir_ch,
                                                       input logic [MAX_BITS-1:0] nop_ir);
      logic [MAX_BITS-1:0] lane_mask;
      lane_mask   = (MAX_BITS'(1) << width) - MAX_BITS'(1);
      bubble_word = '0;
      if (ir_ch >= 0 && ir_ch < nch)
         bubble_word = (nop_ir & lane_mask) << (ir_ch * width);
   endfunction

endpackage

// File: rtl/pipe_reg_en.sv
// Enabled register with asynchronous active-high reset to a fixed value.
module pipe_reg_en #(
   parameter int WIDTH = 32,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= RST_VAL;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/pipe_latch_skid.sv
// Pipeline-stage latch: NCH channels of WIDTH bits with ready/valid handshake
// and a 2-entry skid buffer so in_ready is a pure decode of the state register.
module pipe_latch_skid
   import pipe_latch_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NCH   = 3,
   parameter int IR_CH = NCH - 1,
   parameter logic [WIDTH-1:0] NOP_IR = '0
) (
   input  logic                 clock,
   input  logic                 ctrl_reset,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [NCH*WIDTH-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [NCH*WIDTH-1:0] out_data,
   output logic [1:0]           occupancy
);

   localparam int DW = NCH * WIDTH;
   localparam logic [MAX_BITS-1:0] BUBBLE_WIDE =
      bubble_word(NCH, WIDTH, IR_CH, MAX_BITS'(NOP_IR));
   localparam logic [DW-1:0] BUBBLE = BUBBLE_WIDE[DW-1:0];

   // Handshake: a word moves upstream->stage when in_valid & in_ready at a rising
   // edge, and stage->downstream when out_valid & out_ready; neither ready
   // depends combinationally on the other side's signals.

   state_t          state, state_next;
   logic            main_en, skid_en;
   logic [DW-1:0]   main_d, skid_d, main_q, skid_q;

   always_comb begin
      state_next = state;
      main_en    = 1'b0;
      main_d     = in_data;
      skid_en    = 1'b0;
      skid_d     = in_data;
      if (flush) begin
         state_next = ST_EMPTY;
         main_en    = 1'b1;
         main_d     = BUBBLE;
         skid_en    = 1'b1;
         skid_d     = BUBBLE;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (in_valid) begin
                  main_en    = 1'b1;
                  state_next = ST_FULL;
               end
            end
            ST_FULL: begin
               if (in_valid && out_ready) begin
                  main_en = 1'b1;
               end else if (out_ready) begin
                  // Draining to empty loads the bubble so out_data never shows stale data.
                  main_en    = 1'b1;
                  main_d     = BUBBLE;
                  state_next = ST_EMPTY;
               end else if (in_valid) begin
                  skid_en    = 1'b1;
                  state_next = ST_SKID;
               end
            end
            ST_SKID: begin
               if (out_ready) begin
                  main_en    = 1'b1;
                  main_d     = skid_q;
                  state_next = ST_FULL;
               end
            end
            default: state_next = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset)
         state <= ST_EMPTY;
      else
         state <= state_next;
   end

   pipe_reg_en #(.WIDTH(DW), .RST_VAL(BUBBLE)) u_main (
      .clk (clock),
      .rst (ctrl_reset),
      .en  (main_en),
      .d   (main_d),
      .q   (main_q)
   );

   pipe_reg_en #(.WIDTH(DW), .RST_VAL(BUBBLE)) u_skid (
      .clk (clock),
      .rst (ctrl_reset),
      .en  (skid_en),
      .d   (skid_d),
      .q   (skid_q)
   );

   assign in_ready  = (state != ST_SKID);
   assign out_valid = (state != ST_EMPTY);
   assign out_data  = main_q;
   assign occupancy = state;

endmodule
